// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_pkg
//   Shared definitions for the pipeline hazard controller and its users:
//   - hazard_state_e : controller FSM encodings (RUN / MEM_WAIT)
//   - FWD_REG/FWD_MEM/FWD_WB : EX operand forwarding select codes
//   - INSTR_WIDTH : datapath width of the alu_res muxes driven by fwd_* selects
//   - reg_match() : source/destination compare that never matches register 0
// -----------------------------------------------------------------------------
package hazard_ctrl_pkg;

  localparam int INSTR_WIDTH = 32;
  localparam int REG_W       = 5;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } hazard_state_e;

  localparam logic [1:0] FWD_REG = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_MEM = 2'b01;  // operand from EX_MEM alu_res
  localparam logic [1:0] FWD_WB  = 2'b10;  // operand from write-back value

  // Register 0 is hard-wired zero, so a write to it is never a real producer.
  function automatic logic reg_match(input logic [REG_W-1:0] src,
                                     input logic [REG_W-1:0] dst);
    return (dst != '0) && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// -----------------------------------------------------------------------------
// hazard_fwd_unit
//   Purely combinational forwarding-select logic.
//   Inputs : ex_rs/ex_rt (EX sources), id_rs/id_rt (ID compare sources),
//            mem_rd/mem_w_reg_ena/mem_mem_r (MEM producer),
//            wb_rd/wb_w_reg_ena (WB producer)
//   Outputs: fwd_a/fwd_b (EX operand select), fwd_id_a/fwd_id_b (ID compare
//            operand taken from EX_MEM alu_res)
// -----------------------------------------------------------------------------
module hazard_fwd_unit
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] mem_rd,
  input  logic       mem_w_reg_ena,
  input  logic       mem_mem_r,
  input  logic [4:0] wb_rd,
  input  logic       wb_w_reg_ena,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       fwd_id_a,
  output logic       fwd_id_b
);

  // A load in MEM has no alu_res worth forwarding; its data arrives in WB.
  logic mem_src_ok;
  assign mem_src_ok = mem_w_reg_ena && !mem_mem_r;

  function automatic logic [1:0] ex_sel(input logic [4:0] src,
                                        input logic [4:0] m_rd, input logic m_ok,
                                        input logic [4:0] w_rd, input logic w_ok);
    if (m_ok && reg_match(src, m_rd)) return FWD_MEM;  // youngest producer wins
    if (w_ok && reg_match(src, w_rd)) return FWD_WB;
    return FWD_REG;
  endfunction

  always_comb begin
    fwd_a    = ex_sel(ex_rs, mem_rd, mem_src_ok, wb_rd, wb_w_reg_ena);
    fwd_b    = ex_sel(ex_rt, mem_rd, mem_src_ok, wb_rd, wb_w_reg_ena);
    fwd_id_a = mem_src_ok && reg_match(id_rs, mem_rd);
    fwd_id_b = mem_src_ok && reg_match(id_rt, mem_rd);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Stall/flush controller for the 5-stage core.
//   Inputs : clk, rst (async, active-high); ID/EX/MEM/WB register ids and
//            write/load flags; id_branch/id_br_taken; dmem_req/dmem_ready.
//   Outputs: stall_* (bank hold) and clear_* (bank bubble) for IF_ID, ID_EX,
//            EX_MEM, MEM_WB plus stall_pc; fwd_a/fwd_b/fwd_id_a/fwd_id_b;
//            stall_cnt (saturating count of stall_pc cycles); mem_err (sticky
//            memory-wait timeout); state_dbg (FSM state for observation).
//   Stall priority: memory wait > load-use > branch operand hazard.
// -----------------------------------------------------------------------------
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int TO_W        = 8,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_branch,
  input  logic             id_br_taken,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       ex_rd,
  input  logic             ex_w_reg_ena,
  input  logic             ex_mem_r,
  input  logic [4:0]       mem_rd,
  input  logic             mem_w_reg_ena,
  input  logic             mem_mem_r,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic [4:0]       wb_rd,
  input  logic             wb_w_reg_ena,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             stall_id_ex,
  output logic             stall_ex_mem,
  output logic             stall_mem_wb,
  output logic             clear_if_id,
  output logic             clear_id_ex,
  output logic             clear_ex_mem,
  output logic             clear_mem_wb,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             fwd_id_a,
  output logic             fwd_id_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             mem_err,
  output hazard_state_e    state_dbg
);

  // Last wait-cycle index before mem_err fires (unused when MEM_TIMEOUT = 0).
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  hazard_state_e    state_q, state_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             mem_err_q, mem_err_d;

  logic [1:0] fwd_a_raw, fwd_b_raw;
  logic       fwd_id_a_raw, fwd_id_b_raw;

  logic mem_stall;   // MEM stage waiting on data memory this cycle
  logic ld_use;      // EX load feeds an ID source
  logic br_haz;      // ID branch compare operand not yet available
  logic id_bubble;   // 1-cycle bubble inserted between ID and EX

  hazard_fwd_unit u_fwd (
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .mem_rd       (mem_rd),
    .mem_w_reg_ena(mem_w_reg_ena),
    .mem_mem_r    (mem_mem_r),
    .wb_rd        (wb_rd),
    .wb_w_reg_ena (wb_w_reg_ena),
    .fwd_a        (fwd_a_raw),
    .fwd_b        (fwd_b_raw),
    .fwd_id_a     (fwd_id_a_raw),
    .fwd_id_b     (fwd_id_b_raw)
  );

  // Next-state and stall/clear decode.
  always_comb begin
    state_d   = state_q;
    mem_stall = 1'b0;
    case (state_q)
      ST_RUN: begin
        mem_stall = dmem_req && !dmem_ready;
        if (mem_stall) state_d = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        // The access is already in flight; only ready releases it.
        mem_stall = !dmem_ready;
        if (dmem_ready) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    ld_use = ex_mem_r && (reg_match(id_rs, ex_rd) || reg_match(id_rt, ex_rd));
    // A branch behind a load sees the load twice: first in EX (covered by
    // ld_use), then in MEM via the mem_mem_r term, giving two bubbles.
    br_haz = id_branch &&
             ((ex_w_reg_ena && (reg_match(id_rs, ex_rd) || reg_match(id_rt, ex_rd))) ||
              (mem_mem_r   && (reg_match(id_rs, mem_rd) || reg_match(id_rt, mem_rd))));
    id_bubble = !mem_stall && (ld_use || br_haz);

    stall_pc     = mem_stall || id_bubble;
    stall_if_id  = mem_stall || id_bubble;
    stall_id_ex  = mem_stall;
    stall_ex_mem = mem_stall;
    stall_mem_wb = 1'b0;
    // A stalled branch is re-evaluated later, so it only flushes when free.
    clear_if_id  = !stall_pc && id_branch && id_br_taken;
    clear_id_ex  = id_bubble;
    clear_ex_mem = 1'b0;
    clear_mem_wb = mem_stall;
    fwd_a        = fwd_a_raw;
    fwd_b        = fwd_b_raw;
    fwd_id_a     = fwd_id_a_raw;
    fwd_id_b     = fwd_id_b_raw;

    // Counters and sticky error.
    if (mem_stall) to_cnt_d = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + TO_W'(1);
    else           to_cnt_d = '0;
    mem_err_d = mem_err_q ||
                ((MEM_TIMEOUT != 0) && mem_stall && (to_cnt_q >= TO_LAST));
    stall_cnt_d = (stall_pc && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1)
                                                    : stall_cnt_q;

    // Reset forces every control output inactive without waiting for a clock.
    if (rst) begin
      stall_pc     = 1'b0;
      stall_if_id  = 1'b0;
      stall_id_ex  = 1'b0;
      stall_ex_mem = 1'b0;
      clear_if_id  = 1'b0;
      clear_id_ex  = 1'b0;
      clear_mem_wb = 1'b0;
      fwd_a        = FWD_REG;
      fwd_b        = FWD_REG;
      fwd_id_a     = 1'b0;
      fwd_id_b     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      to_cnt_q    <= '0;
      stall_cnt_q <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign mem_err   = mem_err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed bench: a table of single-cycle vectors for forwarding and
//   ID-stage hazards, then hand-written sequences for load-use, memory wait,
//   timeout, reset mid-wait, branch-on-load and counter saturation.
//   Inputs change 1 ns after posedge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int CNT_W = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic id_branch, id_br_taken, ex_w_reg_ena, ex_mem_r;
  logic mem_w_reg_ena, mem_mem_r, dmem_req, dmem_ready, wb_w_reg_ena;
  logic stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
  logic clear_if_id, clear_id_ex, clear_ex_mem, clear_mem_wb;
  logic [1:0] fwd_a, fwd_b;
  logic fwd_id_a, fwd_id_b, mem_err;
  logic [CNT_W-1:0] stall_cnt;
  hazard_state_e state_dbg;

  hazard_ctrl #(.CNT_W(CNT_W), .TO_W(8), .MEM_TIMEOUT(3)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_branch(id_branch), .id_br_taken(id_br_taken),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_w_reg_ena(ex_w_reg_ena),
    .ex_mem_r(ex_mem_r), .mem_rd(mem_rd), .mem_w_reg_ena(mem_w_reg_ena),
    .mem_mem_r(mem_mem_r), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .wb_rd(wb_rd), .wb_w_reg_ena(wb_w_reg_ena),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
    .stall_ex_mem(stall_ex_mem), .stall_mem_wb(stall_mem_wb),
    .clear_if_id(clear_if_id), .clear_id_ex(clear_id_ex),
    .clear_ex_mem(clear_ex_mem), .clear_mem_wb(clear_mem_wb),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_id_a(fwd_id_a), .fwd_id_b(fwd_id_b),
    .stall_cnt(stall_cnt), .mem_err(mem_err), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [14:0] exp_q[$];

  // Output word: {stall pc,if_id,id_ex,ex_mem,mem_wb | clear if_id,id_ex,
  // ex_mem,mem_wb | fwd_a | fwd_b | fwd_id_a | fwd_id_b}
  function automatic logic [14:0] mk_o(input logic [4:0] st, input logic [3:0] cl,
                                       input logic [1:0] fa, input logic [1:0] fb,
                                       input logic fia, input logic fib);
    return {st, cl, fa, fb, fia, fib};
  endfunction

  function automatic logic [14:0] get_o();
    return {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
            clear_if_id, clear_id_ex, clear_ex_mem, clear_mem_wb,
            fwd_a, fwd_b, fwd_id_a, fwd_id_b};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected word goes through the queue so every output check is ordered.
  task automatic check_o(input string nm, input logic [14:0] exp);
    logic [14:0] e;
    exp_q.push_back(exp);
    e = exp_q.pop_front();
    check(nm, 32'(get_o()), 32'(e));
  endtask

  // Stall and clear on the same bank must never coincide.
  always @(negedge clk) begin
    checks++;
    if ((stall_if_id && clear_if_id) || (stall_id_ex && clear_id_ex) ||
        (stall_ex_mem && clear_ex_mem) || (stall_mem_wb && clear_mem_wb)) begin
      errors++;
      $display("FAIL stall_clear_excl: got %b expected no overlap at %0t", get_o(), $time);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = 0; id_rt = 0; id_branch = 0; id_br_taken = 0;
    ex_rs = 0; ex_rt = 0; ex_rd = 0; ex_w_reg_ena = 0; ex_mem_r = 0;
    mem_rd = 0; mem_w_reg_ena = 0; mem_mem_r = 0;
    dmem_req = 0; dmem_ready = 0; wb_rd = 0; wb_w_reg_ena = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [4:0]  id_rs, id_rt;
    logic        br, tk;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic        ex_w, ex_mr;
    logic [4:0]  mem_rd;
    logic        mem_w, mem_mr;
    logic [4:0]  wb_rd;
    logic        wb_w;
    logic [14:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input string n, input logic [4:0] irs, input logic [4:0] irt,
                     input logic br, input logic tk,
                     input logic [4:0] ers, input logic [4:0] ert, input logic [4:0] erd,
                     input logic ew, input logic emr,
                     input logic [4:0] mrd, input logic mw, input logic mmr,
                     input logic [4:0] wrd, input logic ww, input logic [14:0] exp);
    vec_t v;
    v.name = n; v.id_rs = irs; v.id_rt = irt; v.br = br; v.tk = tk;
    v.ex_rs = ers; v.ex_rt = ert; v.ex_rd = erd; v.ex_w = ew; v.ex_mr = emr;
    v.mem_rd = mrd; v.mem_w = mw; v.mem_mr = mmr; v.wb_rd = wrd; v.wb_w = ww;
    v.exp = exp;
    vecs.push_back(v);
  endtask

  localparam logic [4:0] ST_ID  = 5'b11000;  // stall_pc + stall_if_id
  localparam logic [4:0] ST_MEM = 5'b11110;  // stall_pc .. stall_ex_mem

  initial begin
    idle_inputs();
    //   name            irs irt br tk ers ert erd ew emr mrd mw mmr wrd ww  expected
    add("idle",          0,  0,  0, 0, 0,  0,  0,  0, 0,  0,  0, 0,  0,  0, mk_o(0, 0, 2'b00, 2'b00, 0, 0));
    add("fwd_a_mem",     0,  0,  0, 0, 3,  0,  0,  0, 0,  3,  1, 0,  3,  1, mk_o(0, 0, 2'b01, 2'b00, 0, 0));
    add("fwd_a_wb",      0,  0,  0, 0, 3,  0,  0,  0, 0,  3,  0, 0,  3,  1, mk_o(0, 0, 2'b10, 2'b00, 0, 0));
    add("fwd_a_r0",      0,  0,  0, 0, 0,  0,  0,  0, 0,  0,  1, 0,  0,  1, mk_o(0, 0, 2'b00, 2'b00, 0, 0));
    add("fwd_b_wb",      0,  0,  0, 0, 0,  4,  0,  0, 0,  0,  0, 0,  4,  1, mk_o(0, 0, 2'b00, 2'b10, 0, 0));
    add("fwd_mem_load",  0,  0,  0, 0, 3,  0,  0,  0, 0,  3,  1, 1,  3,  1, mk_o(0, 0, 2'b10, 2'b00, 0, 0));
    add("fwd_both_mem",  0,  0,  0, 0, 6,  6,  0,  0, 0,  6,  1, 0,  0,  0, mk_o(0, 0, 2'b01, 2'b01, 0, 0));
    add("lu_rs",         5,  0,  0, 0, 0,  0,  5,  1, 1,  0,  0, 0,  0,  0, mk_o(ST_ID, 4'b0100, 2'b00, 2'b00, 0, 0));
    add("lu_rt",         0,  5,  0, 0, 0,  0,  5,  1, 1,  0,  0, 0,  0,  0, mk_o(ST_ID, 4'b0100, 2'b00, 2'b00, 0, 0));
    add("lu_r0",         0,  0,  0, 0, 0,  0,  0,  1, 1,  0,  0, 0,  0,  0, mk_o(0, 0, 2'b00, 2'b00, 0, 0));
    add("br_ex_alu",     7,  0,  1, 0, 0,  0,  7,  1, 0,  0,  0, 0,  0,  0, mk_o(ST_ID, 4'b0100, 2'b00, 2'b00, 0, 0));
    add("br_taken",      1,  2,  1, 1, 0,  0,  0,  0, 0,  0,  0, 0,  0,  0, mk_o(0, 4'b1000, 2'b00, 2'b00, 0, 0));
    add("br_mem_load",   0,  7,  1, 1, 0,  0,  0,  0, 0,  7,  1, 1,  0,  0, mk_o(ST_ID, 4'b0100, 2'b00, 2'b00, 0, 0));
    add("br_mem_fwd",    7,  0,  1, 1, 0,  0,  0,  0, 0,  7,  1, 0,  0,  0, mk_o(0, 4'b1000, 2'b00, 2'b00, 1, 0));
    add("alu_no_br",     7,  0,  0, 0, 0,  0,  7,  1, 0,  0,  0, 0,  0,  0, mk_o(0, 0, 2'b00, 2'b00, 0, 0));
    add("br_not_taken",  1,  2,  1, 0, 0,  0,  0,  0, 0,  0,  0, 0,  0,  0, mk_o(0, 0, 2'b00, 2'b00, 0, 0));
    add("br_ex_no_wena", 7,  0,  1, 0, 0,  0,  7,  0, 0,  0,  0, 0,  0,  0, mk_o(0, 0, 2'b00, 2'b00, 0, 0));

    // ---- reset state ----
    #2;
    check_o("rst_outputs", mk_o(0, 0, 2'b00, 2'b00, 0, 0));
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_mem_err", 32'(mem_err), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_RUN));
    do_reset();

    // ---- table ----
    foreach (vecs[i]) begin
      idle_inputs();
      id_rs = vecs[i].id_rs; id_rt = vecs[i].id_rt;
      id_branch = vecs[i].br; id_br_taken = vecs[i].tk;
      ex_rs = vecs[i].ex_rs; ex_rt = vecs[i].ex_rt; ex_rd = vecs[i].ex_rd;
      ex_w_reg_ena = vecs[i].ex_w; ex_mem_r = vecs[i].ex_mr;
      mem_rd = vecs[i].mem_rd; mem_w_reg_ena = vecs[i].mem_w; mem_mem_r = vecs[i].mem_mr;
      wb_rd = vecs[i].wb_rd; wb_w_reg_ena = vecs[i].wb_w;
      #1;
      check_o(vecs[i].name, vecs[i].exp);
      step();
    end

    // ---- load-use: lw r5 in EX, add uses r5 in ID ----
    do_reset();
    id_rs = 5; ex_rd = 5; ex_w_reg_ena = 1; ex_mem_r = 1;
    #1; check_o("lu_seq_c1", mk_o(ST_ID, 4'b0100, 2'b00, 2'b00, 0, 0));
    step();
    idle_inputs();                                   // bubble in EX, lw in MEM
    id_rs = 5; mem_rd = 5; mem_w_reg_ena = 1; mem_mem_r = 1;
    #1; check_o("lu_seq_c2", mk_o(0, 0, 2'b00, 2'b00, 0, 0));
    step();
    idle_inputs();                                   // add in EX, lw in WB
    ex_rs = 5; wb_rd = 5; wb_w_reg_ena = 1;
    #1; check_o("lu_seq_c3_fwd", mk_o(0, 0, 2'b10, 2'b00, 0, 0));
    step();
    check("lu_seq_cnt", 32'(stall_cnt), 32'd1);

    // ---- memory wait, 4 cycles; timeout 3 fires along the way ----
    do_reset();
    for (int i = 0; i < 4; i++) begin
      dmem_req = 1; dmem_ready = 0;
      #1; check_o($sformatf("memw_c%0d", i), mk_o(ST_MEM, 4'b0001, 2'b00, 2'b00, 0, 0));
      step();
      check($sformatf("memw_state_c%0d", i), 32'(state_dbg), 32'(ST_MEM_WAIT));
      if (i == 1) check("memw_err_before", 32'(mem_err), 32'd0);
      if (i == 2) check("memw_err_at3", 32'(mem_err), 32'd1);
    end
    dmem_ready = 1;
    #1; check_o("memw_release", mk_o(0, 0, 2'b00, 2'b00, 0, 0));
    step();
    idle_inputs();
    check("memw_state_run", 32'(state_dbg), 32'(ST_RUN));
    check("memw_cnt", 32'(stall_cnt), 32'd4);
    check("memw_err_sticky", 32'(mem_err), 32'd1);
    step();
    check("memw_err_sticky2", 32'(mem_err), 32'd1);

    // ---- ready with request: no stall ----
    do_reset();
    dmem_req = 1; dmem_ready = 1;
    #1; check_o("mem_fast", mk_o(0, 0, 2'b00, 2'b00, 0, 0));
    step();
    check("mem_fast_state", 32'(state_dbg), 32'(ST_RUN));
    check("mem_fast_cnt", 32'(stall_cnt), 32'd0);

    // ---- reset asserted mid-wait ----
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 4; i++) step();
    check("rstw_pre_err", 32'(mem_err), 32'd1);
    #2; rst = 1'b1;
    #1;
    check_o("rstw_outputs", mk_o(0, 0, 2'b00, 2'b00, 0, 0));
    check("rstw_state", 32'(state_dbg), 32'(ST_RUN));
    check("rstw_cnt", 32'(stall_cnt), 32'd0);
    check("rstw_err", 32'(mem_err), 32'd0);
    idle_inputs();
    step();
    rst = 1'b0;
    step();
    check("rstw_after_state", 32'(state_dbg), 32'(ST_RUN));
    check_o("rstw_after_out", mk_o(0, 0, 2'b00, 2'b00, 0, 0));

    // ---- beq r7 behind lw r7: two bubbles, then flush if taken ----
    do_reset();
    id_branch = 1; id_br_taken = 1; id_rs = 7;
    ex_rd = 7; ex_w_reg_ena = 1; ex_mem_r = 1;
    #1; check_o("bol_c1", mk_o(ST_ID, 4'b0100, 2'b00, 2'b00, 0, 0));
    step();
    ex_rd = 0; ex_w_reg_ena = 0; ex_mem_r = 0;
    mem_rd = 7; mem_w_reg_ena = 1; mem_mem_r = 1;
    #1; check_o("bol_c2", mk_o(ST_ID, 4'b0100, 2'b00, 2'b00, 0, 0));
    step();
    mem_rd = 0; mem_w_reg_ena = 0; mem_mem_r = 0;
    wb_rd = 7; wb_w_reg_ena = 1;
    #1; check_o("bol_c3", mk_o(0, 4'b1000, 2'b00, 2'b00, 0, 0));
    step();
    idle_inputs();
    check("bol_cnt", 32'(stall_cnt), 32'd2);

    // ---- stall counter saturation (3-bit counter, 9 stall cycles) ----
    do_reset();
    dmem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 9; i++) step();
    check("cnt_sat", 32'(stall_cnt), 32'd7);
    dmem_ready = 1;
    step();
    idle_inputs();
    check("cnt_sat_hold", 32'(stall_cnt), 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
